rate_phase_tracking: RTL and testbench

//  Half-period target generator for the clock-generation path, with phase resync to recovered edges.

---
 rtl/clks_alot_p.sv | 15 +
 rtl/phase_error_calc.sv | 54 +++++
 rtl/rate_phase_tracking.sv | 160 ++++++++++++++++
 tb/tb_rate_phase_tracking.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clks_alot_p.sv
// rtl/clks_alot_p.sv - shared types for the clock-generation rate/phase tracker
package clks_alot_p;

    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } rate_track_state_e;

    typedef logic signed [DEFAULT_CNT_W-1:0] phase_err_t;

endpackage

// File: rtl/phase_error_calc.sv
// rtl/phase_error_calc.sv - recovered-edge stamp capture, phase error and clamped trim
module phase_error_calc #(
    parameter int CNT_W          = 16,
    parameter int MAX_CORRECTION = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic                    clear,
    input  logic                    rec_rise,
    input  logic                    consume,
    input  logic [CNT_W-1:0]        counter,
    output logic signed [CNT_W-1:0] e,
    output logic signed [CNT_W-1:0] trim,
    output logic                    meas_valid
);
    localparam logic signed [CNT_W-1:0] MAX_POS = CNT_W'(MAX_CORRECTION);
    localparam logic signed [CNT_W-1:0] MAX_NEG = -MAX_POS;

    logic [CNT_W-1:0] stamp;
    logic             stamp_valid;

    // A recovered edge coinciding with the generated edge is treated as perfect alignment.
    always_comb begin
        meas_valid = rec_rise | stamp_valid;
        e          = rec_rise ? '0 : $signed(counter - stamp);
        if (e > MAX_POS)
            trim = MAX_POS;
        else if (e < MAX_NEG)
            trim = MAX_NEG;
        else
            trim = e;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp       <= '0;
            stamp_valid <= 1'b0;
        end else if (clk_en) begin
            if (clear) begin
                stamp       <= '0;
                stamp_valid <= 1'b0;
            end else begin
                if (rec_rise)
                    stamp <= counter;
                if (consume)
                    stamp_valid <= 1'b0;
                else if (rec_rise)
                    stamp_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rate_phase_tracking.sv
// rtl/rate_phase_tracking.sv - half-period target generator with phase resync to recovered edges
module rate_phase_tracking
    import clks_alot_p::*;
#(
    parameter int CNT_W          = 16,
    parameter int MAX_CORRECTION = 4,
    parameter int PHASE_WINDOW   = 8,
    parameter int LOCK_EDGES     = 4
) (
    input  logic             clk,
    input  logic             async_rst_n,
    input  logic             clk_en_i,
    input  logic             generation_en_i,
    input  logic             clear_state_i,
    input  logic             resync_en_i,
    input  logic             deltas_locked_i,
    input  logic             rec_rise_i,
    input  logic             gen_edge_i,
    input  logic             clk_state_i,
    input  logic [CNT_W-1:0] high_rate_i,
    input  logic [CNT_W-1:0] low_rate_i,
    input  logic [CNT_W-1:0] counter_current_i,
    output logic [CNT_W-1:0] target_o,
    output logic [CNT_W-1:0] active_half_rate_o,
    output logic [CNT_W-1:0] inactive_half_rate_o,
    output logic [CNT_W-1:0] phase_error_o,
    output logic             phase_locked_o,
    output logic [1:0]       state_o
);
    localparam int                LOCK_W    = $clog2(LOCK_EDGES + 1);
    localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_EDGES);

    rate_track_state_e       state, state_next;
    logic [CNT_W-1:0]        high_shadow, low_shadow;
    logic [LOCK_W-1:0]       lock_cnt, lock_next;
    logic signed [CNT_W-1:0] err, trim, trim_eff;
    logic                    meas_valid;
    logic                    rise, fall, running, tracking, consume, resync_ok, in_window;
    logic [CNT_W:0]          err_abs;
    logic signed [CNT_W+1:0] active_wide;
    logic [CNT_W-1:0]        rise_active;

    assign rise      = gen_edge_i & ~clk_state_i;
    assign fall      = gen_edge_i & clk_state_i;
    assign running   = (state != IDLE);
    assign tracking  = (state == TRACK) || (state == LOCKED);
    assign consume   = running & rise;
    assign resync_ok = deltas_locked_i & resync_en_i;

    phase_error_calc #(
        .CNT_W          (CNT_W),
        .MAX_CORRECTION (MAX_CORRECTION)
    ) u_err (
        .clk        (clk),
        .rst_n      (async_rst_n),
        .clk_en     (clk_en_i),
        .clear      (clear_state_i),
        .rec_rise   (rec_rise_i),
        .consume    (consume),
        .counter    (counter_current_i),
        .e          (err),
        .trim       (trim),
        .meas_valid (meas_valid)
    );

    // Magnitude is one bit wider so the most negative error does not alias to itself.
    assign err_abs   = err[CNT_W-1] ? -{err[CNT_W-1], err} : {err[CNT_W-1], err};
    assign in_window = (err_abs <= (CNT_W+1)'(PHASE_WINDOW));

    // The rising edge uses the freshly sampled high rate, so a rate pair takes effect as a whole period.
    assign trim_eff    = (tracking && meas_valid) ? trim : '0;
    assign active_wide = $signed({2'b00, high_rate_i}) - $signed({{2{trim_eff[CNT_W-1]}}, trim_eff});
    assign rise_active = (active_wide <= 0) ? CNT_W'(1) : active_wide[CNT_W-1:0];

    always_comb begin
        lock_next = lock_cnt;
        if (consume && tracking && meas_valid) begin
            if (!in_window)
                lock_next = '0;
            else if (lock_cnt != LOCK_FULL)
                lock_next = lock_cnt + LOCK_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        if (!generation_en_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:   state_next = RUN;
                RUN:    if (resync_ok) state_next = TRACK;
                TRACK: begin
                    if (!resync_ok)
                        state_next = RUN;
                    else if (lock_next == LOCK_FULL)
                        state_next = LOCKED;
                end
                LOCKED: begin
                    if (!resync_ok)
                        state_next = RUN;
                    else if (consume && meas_valid && !in_window)
                        state_next = TRACK;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state                <= IDLE;
            phase_locked_o       <= 1'b0;
            lock_cnt             <= '0;
            high_shadow          <= '0;
            low_shadow           <= '0;
            target_o             <= '0;
            active_half_rate_o   <= '0;
            inactive_half_rate_o <= '0;
            phase_error_o        <= '0;
        end else if (clk_en_i) begin
            if (clear_state_i) begin
                state                <= IDLE;
                phase_locked_o       <= 1'b0;
                lock_cnt             <= '0;
                high_shadow          <= '0;
                low_shadow           <= '0;
                target_o             <= '0;
                active_half_rate_o   <= '0;
                inactive_half_rate_o <= '0;
                phase_error_o        <= '0;
            end else begin
                state          <= state_next;
                phase_locked_o <= (state_next == LOCKED);
                // Leaving the tracking states forfeits any partial lock progress.
                lock_cnt       <= ((state_next == TRACK) || (state_next == LOCKED)) ? lock_next : '0;

                if ((state == IDLE) || rise) begin
                    high_shadow <= high_rate_i;
                    low_shadow  <= low_rate_i;
                end

                if (consume) begin
                    target_o             <= counter_current_i + rise_active;
                    active_half_rate_o   <= rise_active;
                    inactive_half_rate_o <= low_rate_i;
                    if (meas_valid)
                        phase_error_o <= err;
                end else if (running && fall) begin
                    target_o             <= counter_current_i + low_shadow;
                    active_half_rate_o   <= low_shadow;
                    inactive_half_rate_o <= high_shadow;
                end
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_rate_phase_tracking.sv
// tb/tb_rate_phase_tracking.sv - directed vectors plus randomized run against a reference model
module tb_rate_phase_tracking;
    import clks_alot_p::*;

    logic        clk = 1'b0;
    logic        async_rst_n, clk_en_i, generation_en_i, clear_state_i, resync_en_i;
    logic        deltas_locked_i, rec_rise_i, gen_edge_i, clk_state_i;
    logic [15:0] high_rate_i, low_rate_i, counter_current_i;
    logic [15:0] target_o, active_half_rate_o, inactive_half_rate_o, phase_error_o;
    logic        phase_locked_o;
    logic [1:0]  state_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rate_phase_tracking dut (
        .clk                  (clk),
        .async_rst_n          (async_rst_n),
        .clk_en_i             (clk_en_i),
        .generation_en_i      (generation_en_i),
        .clear_state_i        (clear_state_i),
        .resync_en_i          (resync_en_i),
        .deltas_locked_i      (deltas_locked_i),
        .rec_rise_i           (rec_rise_i),
        .gen_edge_i           (gen_edge_i),
        .clk_state_i          (clk_state_i),
        .high_rate_i          (high_rate_i),
        .low_rate_i           (low_rate_i),
        .counter_current_i    (counter_current_i),
        .target_o             (target_o),
        .active_half_rate_o   (active_half_rate_o),
        .inactive_half_rate_o (inactive_half_rate_o),
        .phase_error_o        (phase_error_o),
        .phase_locked_o       (phase_locked_o),
        .state_o              (state_o)
    );

    typedef struct {
        logic        gen, rs, dl, rec, edg, cst, clr;
        logic [15:0] hi, lo, cnt;
        logic [15:0] t, a, i, p;
        logic        l;
        logic [1:0]  s;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic gen, rs, dl, rec, edg, cst, clr,
                                input logic [15:0] hi, lo, cnt, t, a, i, p,
                                input logic l, input logic [1:0] s);
        vec_t v;
        v.gen = gen; v.rs = rs; v.dl = dl; v.rec = rec; v.edg = edg; v.cst = cst; v.clr = clr;
        v.hi = hi; v.lo = lo; v.cnt = cnt;
        v.t = t; v.a = a; v.i = i; v.p = p; v.l = l; v.s = s;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] t, a, i, p,
                           input logic l, input logic [1:0] s);
        chk({tag, ".target"},   target_o, t);
        chk({tag, ".active"},   active_half_rate_o, a);
        chk({tag, ".inactive"}, inactive_half_rate_o, i);
        chk({tag, ".perr"},     phase_error_o, p);
        chk({tag, ".locked"},   phase_locked_o, l);
        chk({tag, ".state"},    state_o, s);
    endtask

    // Reference model: spec rules evaluated with plain integer arithmetic.
    int m_state, m_hi, m_lo, m_stamp, m_lock, m_tgt, m_act, m_inact, m_err;
    bit m_sv;

    task automatic model_reset();
        m_state = 0; m_hi = 0; m_lo = 0; m_stamp = 0; m_sv = 0; m_lock = 0;
        m_tgt = 0; m_act = 0; m_inact = 0; m_err = 0;
    endtask

    task automatic model_step();
        int e, trim, act, nxt, lk, cnt;
        bit rise, fall, meas, trk, run, oow, ok;
        if (!clk_en_i) return;
        if (clear_state_i) begin
            model_reset();
            return;
        end
        cnt  = int'(counter_current_i);
        rise = gen_edge_i && !clk_state_i;
        fall = gen_edge_i && clk_state_i;
        run  = (m_state != 0);
        trk  = (m_state >= 2);
        ok   = deltas_locked_i && resync_en_i;
        meas = rec_rise_i || m_sv;
        e    = (cnt - m_stamp) & 16'hFFFF;
        if (e >= 32768) e = e - 65536;
        if (rec_rise_i) e = 0;
        lk  = m_lock;
        oow = 0;
        if (run && rise) begin
            trim = 0;
            if (trk && meas) trim = (e > 4) ? 4 : ((e < -4) ? -4 : e);
            act = int'(high_rate_i) - trim;
            if (act < 1) act = 1;
            m_tgt   = (cnt + act) % 65536;
            m_act   = act % 65536;
            m_inact = int'(low_rate_i);
            if (meas) m_err = e & 16'hFFFF;
            if (trk && meas) begin
                if (e <= 8 && e >= -8) lk = (m_lock < 4) ? m_lock + 1 : 4;
                else begin lk = 0; oow = 1; end
            end
        end else if (run && fall) begin
            m_tgt   = (cnt + m_lo) % 65536;
            m_act   = m_lo;
            m_inact = m_hi;
        end
        if (!generation_en_i) nxt = 0;
        else if (m_state == 0) nxt = 1;
        else if (m_state == 1) nxt = ok ? 2 : 1;
        else if (!ok) nxt = 1;
        else if (m_state == 2) nxt = (lk == 4) ? 3 : 2;
        else nxt = oow ? 2 : 3;
        if (nxt < 2) lk = 0;
        if (m_state == 0 || rise) begin
            m_hi = int'(high_rate_i);
            m_lo = int'(low_rate_i);
        end
        if (rec_rise_i) m_stamp = cnt;
        if (run && rise) m_sv = 0;
        else if (rec_rise_i) m_sv = 1;
        m_state = nxt;
        m_lock  = lk;
    endtask

    task automatic drive(input logic gen, rs, dl, rec, edg, cst, clr,
                         input logic [15:0] hi, lo, cnt);
        generation_en_i = gen; resync_en_i = rs; deltas_locked_i = dl;
        rec_rise_i = rec; gen_edge_i = edg; clk_state_i = cst; clear_state_i = clr;
        high_rate_i = hi; low_rate_i = lo; counter_current_i = cnt;
    endtask

    initial begin
        async_rst_n = 1'b0;
        clk_en_i    = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0, 16'd0);
        #3;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 1, 0, 0, 16'd10, 16'd6, 16'd5);
        tick();
        chk_all("reset_hold", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        async_rst_n = 1'b1;

        //          gen rs dl rec edg cst clr  hi  lo  cnt       tgt  act inact perr     l  s
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 10, 6, 99,         0,   0,  0,  0,       0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 10, 6, 100,        110, 10, 6,  0,       0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 20, 6, 105,        110, 10, 6,  0,       0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 20, 6, 110,        116, 6,  10, 0,       0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 20, 6, 116,        136, 20, 6,  0,       0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 10, 6, 120,        136, 20, 6,  0,       0, 2));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 0, 10, 6, 136,        142, 6,  20, 0,       0, 2));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 10, 6, 90,         142, 6,  20, 0,       0, 2));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 10, 6, 100,        106, 6,  6,  10,      0, 2));
        vecs.push_back(mk(1, 1, 1, 0, 1, 1, 0, 10, 6, 106,        112, 6,  10, 10,      0, 2));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 10, 6, 16'hFFFE,   112, 6,  10, 10,      0, 2));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 10, 6, 1,          8,   7,  6,  3,       0, 2));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 10, 6, 200,        210, 10, 6,  0,       0, 2));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 10, 6, 300,        310, 10, 6,  0,       0, 2));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 10, 6, 400,        410, 10, 6,  0,       1, 3));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 10, 6, 491,        410, 10, 6,  0,       1, 3));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 10, 6, 500,        506, 6,  6,  9,       0, 2));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 10, 6, 604,        506, 6,  6,  9,       0, 2));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 10, 6, 600,        614, 14, 6,  16'hFFFC, 0, 2));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 1, 10, 6, 700,        0,   0,  0,  0,       0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2,  3, 0,          0,   0,  0,  0,       0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 2,  3, 10,         0,   0,  0,  0,       0, 2));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 2,  3, 50,         0,   0,  0,  0,       0, 2));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 2,  3, 54,         55,  1,  3,  4,       0, 2));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 2,  3, 56,         55,  1,  3,  4,       0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 2,  3, 60,         55,  1,  3,  4,       0, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].gen, vecs[k].rs, vecs[k].dl, vecs[k].rec, vecs[k].edg,
                  vecs[k].cst, vecs[k].clr, vecs[k].hi, vecs[k].lo, vecs[k].cnt);
            tick();
            chk_all($sformatf("vec%0d", k), vecs[k].t, vecs[k].a, vecs[k].i,
                    vecs[k].p, vecs[k].l, vecs[k].s);
        end

        // clk_en low freezes everything, including a pending clear.
        clk_en_i = 1'b0;
        drive(1, 1, 1, 1, 1, 0, 0, 16'd10, 16'd6, 16'd70);
        tick();
        chk_all("gate_edge", 55, 1, 3, 4, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 1, 16'd10, 16'd6, 16'd71);
        tick();
        chk_all("gate_clear", 55, 1, 3, 4, 0, 0);

        clk_en_i = 1'b1;
        drive(1, 1, 1, 0, 0, 0, 0, 16'd10, 16'd6, 16'd900);
        tick();
        chk("lockseq.run", state_o, 1);
        tick();
        chk("lockseq.track", state_o, 2);
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 1, 1, 1, 0, 0, 16'd10, 16'd6, 16'(1000 + 20 * k));
            tick();
        end
        chk("lockseq.state", state_o, 3);
        chk("lockseq.locked", phase_locked_o, 1);
        chk("lockseq.target", target_o, 1070);

        drive(1, 1, 1, 0, 0, 0, 0, 16'd10, 16'd6, 16'd1100);
        #2;
        async_rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        model_reset();
        counter_current_i = 16'hFF00;
        high_rate_i = 16'd10;
        low_rate_i  = 16'd6;
        async_rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            clk_en_i        = ($urandom_range(0, 9) != 0);
            generation_en_i = ($urandom_range(0, 19) != 0);
            clear_state_i   = ($urandom_range(0, 149) == 0);
            resync_en_i     = ($urandom_range(0, 14) != 0);
            deltas_locked_i = ($urandom_range(0, 14) != 0);
            rec_rise_i      = ($urandom_range(0, 5) == 0);
            gen_edge_i      = ($urandom_range(0, 2) == 0);
            clk_state_i     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                high_rate_i = 16'($urandom_range(0, 40));
                low_rate_i  = 16'($urandom_range(0, 40));
            end
            if ($urandom_range(0, 199) == 0)
                high_rate_i = 16'($urandom_range(0, 65535));
            counter_current_i = counter_current_i + 16'($urandom_range(1, 3));
            model_step();
            tick();
            chk_all($sformatf("rand%0d", c), 16'(m_tgt), 16'(m_act), 16'(m_inact),
                    16'(m_err), (m_state == 3), 2'(m_state));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
